// File: rtl/alu_exec.sv
// Sequential ALU: single-cycle logic/arithmetic ops, iterative 1-bit-per-cycle shifts.
// Start/busy handshake in, registered result with a one-cycle done pulse out.
module alu_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         ALUControl,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     acc_reg, acc_next;
  logic [SHAMT_W-1:0]   cnt_reg, cnt_next;
  logic                 dir_reg, dir_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic                 zero_reg, zero_next;
  logic                 done_reg, done_next;

  logic [SHAMT_W-1:0]   shamt;
  logic                 is_shift;
  logic                 shamt_zero;
  logic                 last_step;
  logic [WIDTH-1:0]     comb_value;
  logic [WIDTH-1:0]     sll_step;
  logic [WIDTH-1:0]     srl_step;
  logic [WIDTH-1:0]     step_value;

  assign shamt      = SrcB[SHAMT_W-1:0];
  assign is_shift   = (ALUControl == OP_SLL) || (ALUControl == OP_SRL);
  assign shamt_zero = (shamt == '0);
  assign last_step  = (cnt_reg == SHAMT_W'(1));

  // One-bit shift of the accumulator, zero fill at the vacated end.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
      if (gi == 0) begin : g_sll_lsb
        assign sll_step[gi] = 1'b0;
      end else begin : g_sll_bit
        assign sll_step[gi] = acc_reg[gi-1];
      end
      if (gi == WIDTH-1) begin : g_srl_msb
        assign srl_step[gi] = 1'b0;
      end else begin : g_srl_bit
        assign srl_step[gi] = acc_reg[gi+1];
      end
    end
  endgenerate

  assign step_value = dir_reg ? srl_step : sll_step;

  // Single-cycle result; shifts with a zero amount pass SrcA through unchanged.
  always_comb begin
    comb_value = '0;
    case (ALUControl)
      OP_ADD:  comb_value = SrcA + SrcB;
      OP_SUB:  comb_value = SrcA - SrcB;
      OP_AND:  comb_value = SrcA & SrcB;
      OP_OR:   comb_value = SrcA | SrcB;
      OP_XOR:  comb_value = SrcA ^ SrcB;
      OP_SLT:  comb_value[0] = ($signed(SrcA) < $signed(SrcB));
      OP_SLL:  comb_value = SrcA;
      OP_SRL:  comb_value = SrcA;
      default: comb_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && is_shift && !shamt_zero) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (is_shift && !shamt_zero) begin
            acc_next = SrcA;
            cnt_next = shamt;
            dir_next = ALUControl[0];
          end else begin
            result_next = comb_value;
            done_next   = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_next = step_value;
        cnt_next = cnt_reg - SHAMT_W'(1);
        if (last_step) begin
          result_next = step_value;
          done_next   = 1'b1;
        end
      end
      default: begin
        done_next = 1'b0;
      end
    endcase
    if (done_next) begin
      zero_next = (result_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      done_reg   <= done_next;
    end
  end

  assign busy      = (state_reg == SHIFT);
  assign done      = done_reg;
  assign ALUResult = result_reg;
  assign Zero      = zero_reg;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: single-cycle ops, iterative shifts, handshake and reset abort.
module tb_alu_exec;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;

  int vectors;
  int miscompares;

  alu_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ALUControl(ALUControl),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .busy(busy),
    .done(done),
    .ALUResult(ALUResult),
    .Zero(Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for exactly one edge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, ALUResult, Zero} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b result=%h zero=%b, required busy=0 done=0 result=0 zero=1",
               busy, done, ALUResult, Zero);
    end
    reset = 1'b0;
    $display("reset: busy=%b done=%b result=%h zero=%b", busy, done, ALUResult, Zero);
  endtask

  task automatic test_add();
    issue(3'b000, 32'd5, 32'd7);
    vectors++;
    if ({done, ALUResult, Zero} !== {1'b1, 32'd12, 1'b0}) begin
      miscompares++;
      $display("FAIL add_5_7: done=%b result=%h zero=%b, required done=1 result=0000000c zero=0",
               done, ALUResult, Zero);
    end
    $display("add 5+7: done=%b result=%h zero=%b", done, ALUResult, Zero);
    @(negedge clk);
    vectors++;
    if ({done, ALUResult} !== {1'b0, 32'd12}) begin
      miscompares++;
      $display("FAIL add_done_drop: done=%b result=%h, required done=0 result=0000000c", done, ALUResult);
    end
  endtask

  task automatic test_logic();
    logic [2:0]  ops [9] = '{3'b001, 3'b101, 3'b101, 3'b001, 3'b000,
                             3'b010, 3'b011, 3'b100, 3'b101};
    logic [31:0] va  [9] = '{32'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF,
                             32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'h8000_0000};
    logic [31:0] vb  [9] = '{32'd3, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd2,
                             32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'h7FFF_FFFF};
    logic [31:0] ex  [9] = '{32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1,
                             32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'd1};
    logic        ez  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], va[i], vb[i]);
      vectors++;
      if ({done, ALUResult, Zero} !== {1'b1, ex[i], ez[i]}) begin
        miscompares++;
        $display("FAIL op%b_vec%0d: done=%b result=%h zero=%b, required done=1 result=%h zero=%b",
                 ops[i], i, done, ALUResult, Zero, ex[i], ez[i]);
      end
      $display("op=%b a=%h b=%h: result=%h zero=%b", ops[i], va[i], vb[i], ALUResult, Zero);
    end
  endtask

  task automatic test_shift(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expv, input int exp_wait,
                            input logic [31:0] prev, input bit noise);
    int waited;
    bit got;
    issue(op, a, b);
    vectors++;
    if ({busy, done, ALUResult} !== {1'b1, 1'b0, prev}) begin
      miscompares++;
      $display("FAIL shift_accept: busy=%b done=%b result=%h, required busy=1 done=0 result=%h",
               busy, done, ALUResult, prev);
    end
    waited = 0;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (noise && (i == 3 || i == 10)) begin
        start = 1'b1; ALUControl = 3'b000; SrcA = 32'd100; SrcB = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      waited++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    vectors++;
    if (!got || waited != exp_wait) begin
      miscompares++;
      $display("FAIL shift_latency: done seen=%0d after %0d edges, required done after %0d edges",
               got, waited, exp_wait);
    end
    vectors++;
    if ({busy, ALUResult, Zero} !== {1'b0, expv, (expv == 32'h0)}) begin
      miscompares++;
      $display("FAIL shift_result: busy=%b result=%h zero=%b, required busy=0 result=%h zero=%b",
               busy, ALUResult, Zero, expv, (expv == 32'h0));
    end
    $display("shift op=%b a=%h b=%h: result=%h after %0d edges", op, a, b, ALUResult, waited);
    @(negedge clk);
    vectors++;
    if ({done, ALUResult} !== {1'b0, expv}) begin
      miscompares++;
      $display("FAIL shift_done_drop: done=%b result=%h, required done=0 result=%h", done, ALUResult, expv);
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    issue(3'b110, 32'd9, 32'd32);
    vectors++;
    if ({busy, done, ALUResult, Zero} !== {1'b0, 1'b1, 32'd9, 1'b0}) begin
      miscompares++;
      $display("FAIL shamt0: busy=%b done=%b result=%h zero=%b, required busy=0 done=1 result=00000009 zero=0",
               busy, done, ALUResult, Zero);
    end
    $display("sll 9 by 32 (shamt 0): result=%h", ALUResult);
    start = 1'b1; ALUControl = 3'b000; SrcA = 32'd2; SrcB = 32'd3;
    @(negedge clk);
    vectors++;
    if ({done, ALUResult} !== {1'b1, 32'd5}) begin
      miscompares++;
      $display("FAIL b2b_add: done=%b result=%h, required done=1 result=00000005", done, ALUResult);
    end
    $display("back-to-back add 2+3: result=%h", ALUResult);
    ALUControl = 3'b110; SrcA = 32'd3; SrcB = 32'd2;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, done} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_shift_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    waited = 0;
    while (!done && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if ({done, ALUResult} !== {1'b1, 32'd12} || waited != 2) begin
      miscompares++;
      $display("FAIL b2b_shift: done=%b result=%h edges=%0d, required done=1 result=0000000c edges=2",
               done, ALUResult, waited);
    end
    $display("back-to-back sll 3 by 2: result=%h after %0d edges", ALUResult, waited);
  endtask

  task automatic test_reset_mid();
    int pulses;
    issue(3'b111, 32'hFFFF_FFFF, 32'd10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, ALUResult, Zero} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h zero=%b, required busy=0 done=0 result=0 zero=1",
               busy, done, ALUResult, Zero);
    end
    reset = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    vectors++;
    if (pulses != 0 || ALUResult !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_abort: stray done/busy cycles=%0d result=%h, required 0 cycles result=0",
               pulses, ALUResult);
    end
    $display("reset mid-shift: busy=%b done=%b result=%h zero=%b", busy, done, ALUResult, Zero);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    start = 1'b0;
    ALUControl = 3'b000;
    SrcA = 32'h0;
    SrcB = 32'h0;
    test_reset();
    test_add();
    test_logic();
    test_shift(3'b110, 32'd1, 32'd4, 32'd16, 4, 32'd1, 1'b0);
    test_shift(3'b111, 32'h8000_0000, 32'd31, 32'd1, 31, 32'd16, 1'b1);
    test_shift(3'b110, 32'hF000_000F, 32'd3, 32'h8000_0078, 3, 32'd1, 1'b0);
    test_shift(3'b111, 32'd1, 32'd1, 32'd0, 1, 32'h8000_0078, 1'b0);
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
